// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings,
// plus bit positions of the NZCV flags inside flags_out.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } alu_state_t;

endpackage

// File: rtl/sequential_alu_if.sv
// Request/response bundle between the datapath controller and the ALU.
// The master issues operations; the slave (the ALU) returns result and flags.
interface sequential_alu_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  start;
  logic [2:0]            opcode;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  set_flags;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [3:0]            flags_out;
  logic                  flags_reg_write_enable;

  modport master (
    output start, opcode, a, b, set_flags,
    input  busy, done, result, flags_out, flags_reg_write_enable
  );

  modport slave (
    input  start, opcode, a, b, set_flags,
    output busy, done, result, flags_out, flags_reg_write_enable
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generation from the final result and the per-op
// carry / shift-out / high-half-nonzero indications.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  alu_op_t               op,
  input  logic                  a_msb,
  input  logic                  b_msb,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  carry,
  input  logic                  shift_out,
  input  logic                  mul_hi_nz,
  output logic [3:0]            flags
);

  logic r_msb;
  assign r_msb = result[DATA_WIDTH-1];

  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_N] = r_msb;
    flags[FLAG_Z] = (result == '0);
    case (op)
      ALU_ADD: begin
        flags[FLAG_C] = carry;
        flags[FLAG_V] = (a_msb == b_msb) && (r_msb != a_msb);
      end
      ALU_SUB: begin
        // carry here is the no-borrow bit of a + ~b + 1
        flags[FLAG_C] = carry;
        flags[FLAG_V] = (a_msb != b_msb) && (r_msb != a_msb);
      end
      ALU_SHL, ALU_SHR: flags[FLAG_C] = shift_out;
      ALU_MUL:          flags[FLAG_C] = mul_hi_nz;
      default: ;
    endcase
  end

endmodule

// File: rtl/sequential_alu.sv
// Multi-cycle integer ALU: one-cycle logic/arithmetic ops, bit-serial shifts
// and a shift-add multiplier behind a common start/busy/done handshake.
module sequential_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  sequential_alu_if.slave bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = ($clog2(W) > 4) ? $clog2(W) : 4;

  alu_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  alu_op_t          op_reg, op_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  logic             set_flags_reg, set_flags_next;
  logic [W-1:0]     work_reg, work_next;
  logic [2*W-1:0]   mcand_reg, mcand_next;
  logic [W-1:0]     mplier_reg, mplier_next;
  logic [2*W-1:0]   prod_reg, prod_next;
  logic [W-1:0]     result_reg, result_next;
  logic [3:0]       flags_reg, flags_next;

  logic [W:0]       sum_ext;
  logic [W:0]       diff_ext;
  logic [3:0]       shift_amt;
  logic [W-1:0]     shl_step;
  logic [W-1:0]     shr_step;
  logic [2*W-1:0]   prod_step;
  logic [W-1:0]     final_result;
  logic             carry;
  logic             shift_out;
  logic             mul_hi_nz;
  logic [3:0]       flags_calc;
  alu_op_t          start_op;
  logic [3:0]       start_amt;

  assign sum_ext   = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff_ext  = {1'b0, a_reg} + {1'b0, ~b_reg} + (W+1)'(1);
  assign shift_amt = b_reg[3:0];
  assign shl_step  = {work_reg[W-2:0], 1'b0};
  assign shr_step  = {1'b0, work_reg[W-1:1]};
  assign prod_step = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign start_op  = alu_op_t'(bus.opcode);
  assign start_amt = bus.b[3:0];

  // Value the result register takes on the last EXEC cycle; multi-cycle ops
  // fold their final iteration in here so no extra cycle is spent.
  always_comb begin
    final_result = '0;
    carry        = 1'b0;
    shift_out    = 1'b0;
    mul_hi_nz    = 1'b0;
    case (op_reg)
      ALU_ADD: begin
        final_result = sum_ext[W-1:0];
        carry        = sum_ext[W];
      end
      ALU_SUB: begin
        final_result = diff_ext[W-1:0];
        carry        = diff_ext[W];
      end
      ALU_AND: final_result = a_reg & b_reg;
      ALU_OR:  final_result = a_reg | b_reg;
      ALU_XOR: final_result = a_reg ^ b_reg;
      ALU_SHL: begin
        if (shift_amt == 4'd0) begin
          final_result = work_reg;
        end else begin
          final_result = shl_step;
          shift_out    = work_reg[W-1];
        end
      end
      ALU_SHR: begin
        if (shift_amt == 4'd0) begin
          final_result = work_reg;
        end else begin
          final_result = shr_step;
          shift_out    = work_reg[0];
        end
      end
      ALU_MUL: begin
        final_result = prod_step[W-1:0];
        mul_hi_nz    = |prod_step[2*W-1:W];
      end
      default: ;
    endcase
  end

  alu_flag_gen #(
    .DATA_WIDTH(W)
  ) u_flag_gen (
    .op        (op_reg),
    .a_msb     (a_reg[W-1]),
    .b_msb     (b_reg[W-1]),
    .result    (final_result),
    .carry     (carry),
    .shift_out (shift_out),
    .mul_hi_nz (mul_hi_nz),
    .flags     (flags_calc)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    set_flags_next = set_flags_reg;
    work_next      = work_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    prod_next      = prod_reg;
    result_next    = result_reg;
    flags_next     = flags_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next     = EXEC;
          op_next        = start_op;
          a_next         = bus.a;
          b_next         = bus.b;
          set_flags_next = bus.set_flags;
          work_next      = bus.a;
          mcand_next     = {{W{1'b0}}, bus.a};
          mplier_next    = bus.b;
          prod_next      = '0;
          // Counter holds the number of EXEC cycles remaining after this one.
          case (start_op)
            ALU_SHL, ALU_SHR:
              cnt_next = (start_amt == 4'd0) ? '0 : CNT_W'(start_amt) - CNT_W'(1);
            ALU_MUL:
              cnt_next = CNT_W'(W - 1);
            default:
              cnt_next = '0;
          endcase
        end
      end
      EXEC: begin
        if (op_reg == ALU_SHL) work_next = shl_step;
        if (op_reg == ALU_SHR) work_next = shr_step;
        if (op_reg == ALU_MUL) begin
          prod_next   = prod_step;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
        end
        if (cnt_reg == '0) begin
          state_next  = DONE;
          result_next = final_result;
          flags_next  = flags_calc;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_reg        <= ALU_ADD;
      a_reg         <= '0;
      b_reg         <= '0;
      set_flags_reg <= 1'b0;
      work_reg      <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      prod_reg      <= '0;
      result_reg    <= '0;
      flags_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      set_flags_reg <= set_flags_next;
      work_reg      <= work_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      prod_reg      <= prod_next;
      result_reg    <= result_next;
      flags_reg     <= flags_next;
    end
  end

  assign bus.busy                   = (state_reg != IDLE);
  assign bus.done                   = (state_reg == DONE);
  assign bus.result                 = result_reg;
  assign bus.flags_out              = flags_reg;
  assign bus.flags_reg_write_enable = (state_reg == DONE) && set_flags_reg;

endmodule

// File: tb/tb_sequential_alu.sv
// Directed bench for sequential_alu: hand-computed results/flags, latency,
// busy span, ignored starts and asynchronous reset mid-operation.
module tb_sequential_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sequential_alu_if #(.DATA_WIDTH(W)) bus ();

  sequential_alu #(
    .DATA_WIDTH(W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start is presented after edge 0 and sampled at edge 1; done must be high
  // right after edge 1+n and busy after every edge from 1 to 1+n.
  task automatic run_op(input string tag, input alu_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sf, input int n,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_fl,
                        input int poke);
    int   k;
    logic busy_ok;
    logic seen;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.opcode    = op;
    bus.a         = a;
    bus.b         = b;
    bus.set_flags = sf;
    k       = 0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == poke) begin
        bus.start     = 1'b1;
        bus.opcode    = ALU_ADD;
        bus.a         = 16'h1111;
        bus.b         = 16'h2222;
        bus.set_flags = 1'b1;
      end
      if (k == poke + 1) bus.start = 1'b0;
      busy_ok &= bus.busy;
      if (bus.done) seen = 1'b1;
    end
    check({tag, " done_edge"}, 32'(k), 32'(1 + n));
    check({tag, " busy_span"}, 32'(busy_ok), 32'd1);
    check({tag, " result"}, 32'(bus.result), 32'(exp_res));
    check({tag, " flags"}, 32'(bus.flags_out), 32'(exp_fl));
    check({tag, " wr_en"}, 32'(bus.flags_reg_write_enable), 32'(sf));
    @(posedge clk);
    @(negedge clk);
    check({tag, " done_drop"}, 32'(bus.done), 32'd0);
    check({tag, " idle"}, 32'(bus.busy), 32'd0);
    check({tag, " wr_en_drop"}, 32'(bus.flags_reg_write_enable), 32'd0);
    check({tag, " hold"}, 32'({bus.flags_out, bus.result}), 32'({exp_fl, exp_res}));
    $display("txn %s op=%0d a=%h b=%h sf=%0d edges=%0d result=%h flags=%b",
             tag, op, a, b, sf, k, bus.result, bus.flags_out);
  endtask

  initial begin
    int   k;
    logic any_done;
    logic any_we;
    logic any_busy;

    bus.start     = 1'b0;
    bus.opcode    = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.set_flags = 1'b0;
    rst           = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset flags", 32'(bus.flags_out), 32'd0);
    check("reset wr_en", 32'(bus.flags_reg_write_enable), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    //      tag          op       a         b         sf  n   result    flags    poke
    run_op("add_ovf",   ALU_ADD, 16'h7FFF, 16'h0001, 1, 1,  16'h8000, 4'b1001, -1);
    run_op("sub_eq",    ALU_SUB, 16'h0005, 16'h0005, 1, 1,  16'h0000, 4'b0110, -1);
    run_op("sub_eq_nf", ALU_SUB, 16'h0005, 16'h0005, 0, 1,  16'h0000, 4'b0110, -1);
    run_op("shl_1",     ALU_SHL, 16'h8001, 16'h0001, 1, 1,  16'h0002, 4'b0010, -1);
    run_op("shl_0",     ALU_SHL, 16'h8001, 16'h0000, 1, 1,  16'h8001, 4'b1000, -1);
    run_op("shr_4",     ALU_SHR, 16'h8001, 16'h0004, 1, 4,  16'h0800, 4'b0000, -1);
    run_op("shr_3",     ALU_SHR, 16'h000F, 16'h0003, 1, 3,  16'h0001, 4'b0010, -1);
    run_op("and",       ALU_AND, 16'hF0F0, 16'hFF00, 1, 1,  16'hF000, 4'b1000, -1);
    run_op("or",        ALU_OR,  16'h1234, 16'h0001, 1, 1,  16'h1235, 4'b0000, -1);
    run_op("xor",       ALU_XOR, 16'hAAAA, 16'hAAAA, 1, 1,  16'h0000, 4'b0100, -1);
    run_op("add_carry", ALU_ADD, 16'hFFFF, 16'h0001, 1, 1,  16'h0000, 4'b0110, -1);
    run_op("mul_hi",    ALU_MUL, 16'h0100, 16'h0100, 1, 16, 16'h0000, 4'b0110, -1);
    run_op("mul_poke",  ALU_MUL, 16'h0003, 16'h0005, 1, 16, 16'h000F, 4'b0000, 5);
    run_op("sub_neg",   ALU_SUB, 16'h0003, 16'h0005, 1, 1,  16'hFFFE, 4'b1000, -1);

    // Abort a multiply with an asynchronous reset between clock edges.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.opcode    = ALU_MUL;
    bus.a         = 16'h0003;
    bus.b         = 16'h0005;
    bus.set_flags = 1'b1;
    k = 0;
    while (k < 8) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    check("abort busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort result", 32'(bus.result), 32'd0);
    check("abort flags", 32'(bus.flags_out), 32'd0);
    check("abort wr_en", 32'(bus.flags_reg_write_enable), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    any_done = 1'b0;
    any_we   = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      any_done |= bus.done;
      any_we   |= bus.flags_reg_write_enable;
      any_busy |= bus.busy;
    end
    check("abort no_done", 32'(any_done), 32'd0);
    check("abort no_wr_en", 32'(any_we), 32'd0);
    check("abort stays_idle", 32'(any_busy), 32'd0);
    $display("txn abort mul at edge 8: busy=%0d result=%h flags=%b",
             bus.busy, bus.result, bus.flags_out);

    run_op("add_after", ALU_ADD, 16'h0002, 16'h0003, 1, 1, 16'h0005, 4'b0000, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
